switch_debounce_select: RTL and testbench



---
 rtl/switch_debounce_select.sv | 83 ++++++++
 tb/tb_switch_debounce_select.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_select.sv
// Input conditioning for the LED blink selector: synchronises and
// debounces two slide switches and a push-button, toggles enable per press.
module switch_debounce_select #(
  parameter int unsigned c_DEBOUNCE_LIMIT = 250,
  parameter logic        c_ENABLE_INIT    = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_switch_1_raw,
  input  logic i_switch_2_raw,
  input  logic i_button_raw,
  output logic o_switch_1,
  output logic o_switch_2,
  output logic o_enable,
  output logic o_select_change
);

  localparam int unsigned c_CW = $clog2(c_DEBOUNCE_LIMIT);
  localparam logic [c_CW-1:0] c_MAX = c_CW'(c_DEBOUNCE_LIMIT - 1);

  // bit 0: switch 2, bit 1: switch 1, bit 2: button
  logic [2:0] raw;
  logic [2:0] meta;
  logic [2:0] sync;
  logic [2:0] deb;

  logic [1:0] sel_prev;
  logic       btn_prev;

  assign raw = {i_button_raw, i_switch_1_raw, i_switch_2_raw};

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic [c_CW-1:0] count;
    logic            level;

    // Count only while the synced input disagrees; any return resets it.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        count <= '0;
        level <= 1'b0;
      end else if (sync[g] == level) begin
        count <= '0;
      end else if (count == c_MAX) begin
        level <= sync[g];
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end

    assign deb[g] = level;
  end

  assign o_switch_2 = deb[0];
  assign o_switch_1 = deb[1];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sel_prev        <= '0;
      btn_prev        <= 1'b0;
      o_enable        <= c_ENABLE_INIT;
      o_select_change <= 1'b0;
    end else begin
      sel_prev        <= deb[1:0];
      btn_prev        <= deb[2];
      o_select_change <= (deb[1:0] != sel_prev);
      if (deb[2] && !btn_prev) begin
        o_enable <= ~o_enable;
      end
    end
  end

endmodule

// File: tb/tb_switch_debounce_select.sv
// Bench for switch_debounce_select: directed steps plus random bounce
// traffic, checked against a run-length reference model.
module tb_switch_debounce_select;

  localparam int L = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw1 = 1'b0;
  logic sw2 = 1'b0;
  logic btn = 1'b0;

  logic o_switch_1;
  logic o_switch_2;
  logic o_enable;
  logic o_select_change;

  int passed = 0;
  int failed = 0;
  int total = 0;

  always #5 clk = ~clk;

  switch_debounce_select #(
    .c_DEBOUNCE_LIMIT(L),
    .c_ENABLE_INIT(1'b1)
  ) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
    .i_switch_1_raw(sw1),
    .i_switch_2_raw(sw2),
    .i_button_raw(btn),
    .o_switch_1(o_switch_1),
    .o_switch_2(o_switch_2),
    .o_enable(o_enable),
    .o_select_change(o_select_change)
  );

  // Reference: raw samples take two edges to reach the filter; a level is
  // accepted once it has disagreed with the output for L edges in a row.
  logic [2:0] h0 = '0;
  logic [2:0] h1 = '0;
  logic [2:0] md = '0;
  int         run [3];
  logic [1:0] m_sel_prev = '0;
  logic       m_btn_prev = 1'b0;
  logic       m_en = 1'b1;
  logic       m_pulse = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [2:0] r;
    if (!rst_n) begin
      h0 = '0;
      h1 = '0;
      md = '0;
      for (int i = 0; i < 3; i++) run[i] = 0;
      m_sel_prev = '0;
      m_btn_prev = 1'b0;
      m_en = 1'b1;
      m_pulse = 1'b0;
    end else begin
      r = {btn, sw1, sw2};
      m_pulse = ({md[1], md[0]} != m_sel_prev);
      m_sel_prev = {md[1], md[0]};
      if (md[2] && !m_btn_prev) m_en = ~m_en;
      m_btn_prev = md[2];
      for (int i = 0; i < 3; i++) begin
        if (h1[i] != md[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == L) begin
            md[i] = h1[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      h1 = h0;
      h0 = r;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("model_sw1", 32'(o_switch_1), 32'(md[1]));
    chk("model_sw2", 32'(o_switch_2), 32'(md[0]));
    chk("model_en", 32'(o_enable), 32'(m_en));
    chk("model_pulse", 32'(o_select_change), 32'(m_pulse));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk_model();
    end
  endtask

  initial begin
    logic exp_en;
    int pulses;

    sw1 = 1'b1;
    sw2 = 1'b1;
    btn = 1'b1;
    rst_n = 1'b0;
    cyc(3);
    chk("rst_sw1", 32'(o_switch_1), 0);
    chk("rst_sw2", 32'(o_switch_2), 0);
    chk("rst_en", 32'(o_enable), 1);
    chk("rst_pulse", 32'(o_select_change), 0);

    rst_n = 1'b1;
    sw2 = 1'b0;
    btn = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      cyc(1);
      if (e == 5) chk("rel_sw1_e5", 32'(o_switch_1), 0);
      if (e == 6) chk("rel_sw1_e6", 32'(o_switch_1), 1);
      if (e == 7) chk("rel_pulse_e7", 32'(o_select_change), 1);
      if (e == 8) chk("rel_pulse_e8", 32'(o_select_change), 0);
    end

    sw2 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cyc(1);
      if (e == 5) chk("step_sw2_e5", 32'(o_switch_2), 0);
      if (e == 6) chk("step_sw2_e6", 32'(o_switch_2), 1);
      if (e == 7) chk("step_pulse_e7", 32'(o_select_change), 1);
      if (e == 8) chk("step_pulse_e8", 32'(o_select_change), 0);
    end

    sw1 = 1'b0;
    cyc(10);
    sw1 = 1'b1;
    cyc(3);
    sw1 = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      cyc(1);
      chk("glitch_sw1", 32'(o_switch_1), 0);
      chk("glitch_pulse", 32'(o_select_change), 0);
    end

    sw1 = 1'b1;
    cyc(1);
    sw1 = 1'b0;
    cyc(1);
    sw1 = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      cyc(1);
      if (e == 5) chk("bounce_sw1_e5", 32'(o_switch_1), 0);
      if (e == 6) chk("bounce_sw1_e6", 32'(o_switch_1), 1);
      if (e == 7) chk("bounce_pulse_e7", 32'(o_select_change), 1);
    end

    exp_en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      btn = 1'b1;
      cyc(10);
      btn = 1'b0;
      cyc(10);
      exp_en = ~exp_en;
      chk("press_en", 32'(o_enable), 32'(exp_en));
    end
    btn = 1'b1;
    cyc(50);
    exp_en = ~exp_en;
    chk("hold_en", 32'(o_enable), 32'(exp_en));
    btn = 1'b0;
    cyc(10);
    chk("release_en", 32'(o_enable), 32'(exp_en));

    sw1 = 1'b0;
    sw2 = 1'b0;
    cyc(10);
    sw1 = 1'b1;
    sw2 = 1'b1;
    pulses = 0;
    for (int e = 1; e <= 12; e++) begin
      cyc(1);
      if (o_select_change) pulses++;
      if (e == 5) chk("simul_sw1_e5", 32'(o_switch_1), 0);
      if (e == 6) chk("simul_both_e6", 32'({o_switch_1, o_switch_2}), 3);
    end
    chk("simul_pulses", 32'(pulses), 1);

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(4) == 0) sw1 = ~sw1;
      if ($urandom_range(4) == 0) sw2 = ~sw2;
      if ($urandom_range(5) == 0) btn = ~btn;
      cyc(1);
    end

    sw1 = 1'b0;
    sw2 = 1'b1;
    btn = 1'b0;
    cyc(12);
    sw1 = 1'b1;
    cyc(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sw1", 32'(o_switch_1), 0);
    chk("arst_sw2", 32'(o_switch_2), 0);
    chk("arst_en", 32'(o_enable), 1);
    chk("arst_pulse", 32'(o_select_change), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      cyc(1);
      if (e == 5) chk("arst_sw1_e5", 32'(o_switch_1), 0);
      if (e == 6) chk("arst_both_e6", 32'({o_switch_1, o_switch_2}), 3);
    end
    cyc(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
